packet_store: RTL
=================

// Module: packet_store
// PURPOSE
// Upstream stage of credit_return: accepts 16-bit packets (tlast-delimited), writes payload into ram256x256 (ram_b)
// and descriptor {size,addr} into ram256x16 (ram_a), then issues the 8-bit slot index on an AXI-Stream to credit_return.
// Slot index = ram_a address = ram_b row; slots are recycled via a release (credit) input from the consumer side.
// PARAMETERS
// N_SLOTS    16   number of buffer slots in use (1..256); slot indices 0..N_SLOTS-1
// MAX_WORDS  16   max payload words per packet (1..16, one ram_b row)
// PORTS
// aclk          in   1   clock
// aresetn       in   1   synchronous active-low reset
// in_tdata      in   16  payload word
// in_tvalid     in   1   payload valid
// in_tlast      in   1   last word of packet
// in_tready     out  1   payload ready
// wr_a_addr     out  8   ram_a write address (slot)
// wr_a_data     out  16  ram_a write data {size[7:0], addr[7:0]}
// wr_a_valid    out  1   ram_a write strobe
// wr_b_addr     out  12  ram_b word address {row[7:0], word[3:0]}
// wr_b_data     out  16  ram_b write data
// wr_b_valid    out  1   ram_b write strobe
// out_tdata     out  8   slot index to credit_return in_tdata
// out_tvalid    out  1   slot index valid
// out_tready    in   1   credit_return in_tready
// rel_slot      in   8   slot being released (credit return)
// rel_valid     in   1   release strobe, one slot per cycle
// free_cnt      out  9   number of free slots
// err_trunc     out  1   1-cycle pulse: packet exceeded MAX_WORDS
// err_dbl_free  out  1   1-cycle pulse: release of an already-free or out-of-range slot
// BEHAVIOUR
// - Reset (aresetn=0 at posedge): all slots free, free_cnt=N_SLOTS, FSM=IDLE; every out/strobe/err = 0; addr/data = 0.
// - FSM: IDLE -> ALLOC when any slot free; ALLOC picks lowest-index free slot, marks busy, wcnt=0 -> RECV.
//   RECV: in_tready=1; each in_tvalid&in_tready word: if wcnt<MAX_WORDS write it, wcnt++; else discard.
//   RECV -> DESC on the accepted beat with in_tlast=1. DESC: one ram_a write -> PUSH.
//   PUSH: out_tvalid=1, out_tdata=slot; held stable until out_tready; on handshake -> IDLE.
// - in_tready is 0 in all states except RECV; out_tvalid only in PUSH (AXIS: no retraction, data stable).
// - RAM writes are registered: word accepted at edge T -> wr_b_valid=1 for exactly cycle T..T+1,
//   wr_b_addr={slot,wcnt[3:0]}, wr_b_data=word. Last word at edge T -> wr_a_valid in the following cycle (DESC),
//   wr_a_addr=slot, wr_a_data={size,slot}, size=min(words,MAX_WORDS); out_tvalid asserted the cycle after.
// - Overflow: words beyond MAX_WORDS are consumed (in_tready stays 1) but not written; err_trunc pulses once,
//   on the DESC cycle; size saturates at MAX_WORDS. Packet length >=1 always (tlast rides a word).
// - Release: rel_valid with busy slot < N_SLOTS marks it free next cycle. Free or out-of-range -> ignored, err_dbl_free pulse.
//   Release and allocation in the same cycle both take effect; free_cnt = old -1 +1. Releasing the slot being
//   allocated that cycle is impossible (it was free) -> err_dbl_free.
// - No free slot: FSM waits in IDLE, in_tready=0 (backpressure to source); free_cnt=0.
// - free_cnt updated every cycle from bitmap count; never exceeds N_SLOTS.
// - Reset mid-packet: partial packet abandoned, no descriptor issued, all slots freed.
// TESTING
// 1 Reset, N_SLOTS=16: one 3-word packet 0x1111,0x2222,0x3333(tlast) -> ram_b[0x000..0x002] written, ram_a[0]=0x0300, out_tdata=0x00.
// 2 Two packets back-to-back, out_tready=1 -> slots 0 then 1; ram_a[1]={len,0x01}; free_cnt 16->15->14.
// 3 20-word packet -> 16 ram_b writes only, ram_a[slot]=0x10xx, one err_trunc pulse, all 20 beats accepted.
// 4 Send 16 packets without release -> free_cnt=0, in_tready stays 0; rel_slot=5 -> next packet uses slot 5.
// 5 out_tready held 0 for 10 cycles in PUSH -> out_tvalid/out_tdata stable; release of free slot 9 -> err_dbl_free=1.
// 6 Chain with credit_return+ram models, random tvalid/tready gaps, release on consumed packet -> output stream
//   equals input payload order, 500 packets, zero mismatches.

Source files
------------

// File: rtl/packet_store_if.sv
// Bundles the packet store's streaming, RAM write, release and status signals.
// The slave modport is the packet store itself; the master modport is its environment.
interface packet_store_if;
    logic [15:0] in_tdata;
    logic        in_tvalid;
    logic        in_tlast;
    logic        in_tready;

    logic [7:0]  wr_a_addr;
    logic [15:0] wr_a_data;
    logic        wr_a_valid;

    logic [11:0] wr_b_addr;
    logic [15:0] wr_b_data;
    logic        wr_b_valid;

    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready;

    logic [7:0]  rel_slot;
    logic        rel_valid;

    logic [8:0]  free_cnt;
    logic        err_trunc;
    logic        err_dbl_free;

    modport slave (
        input  in_tdata, in_tvalid, in_tlast,
        output in_tready,
        output wr_a_addr, wr_a_data, wr_a_valid,
        output wr_b_addr, wr_b_data, wr_b_valid,
        output out_tdata, out_tvalid,
        input  out_tready,
        input  rel_slot, rel_valid,
        output free_cnt, err_trunc, err_dbl_free
    );

    modport master (
        output in_tdata, in_tvalid, in_tlast,
        input  in_tready,
        input  wr_a_addr, wr_a_data, wr_a_valid,
        input  wr_b_addr, wr_b_data, wr_b_valid,
        input  out_tdata, out_tvalid,
        output out_tready,
        output rel_slot, rel_valid,
        input  free_cnt, err_trunc, err_dbl_free
    );
endinterface

// File: rtl/packet_store.sv
// Packet buffer front end: allocates a slot per packet, stores payload and descriptor
// through registered RAM write ports, then hands the slot index downstream.
module packet_store #(
    parameter int N_SLOTS   = 16,
    parameter int MAX_WORDS = 16
) (
    input logic           aclk,
    input logic           aresetn,
    packet_store_if.slave bus
);

    localparam logic [4:0] MAXW = 5'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALLOC,
        S_RECV,
        S_DESC,
        S_PUSH
    } state_t;

    state_t               state_q, state_d;
    logic [N_SLOTS-1:0]   busy_q, busy_d;
    logic [7:0]           slot_q, slot_d;
    logic [4:0]           wcnt_q, wcnt_d;
    logic                 wrb_vld_q, wrb_vld_d;
    logic [11:0]          wrb_addr_q, wrb_addr_d;
    logic [15:0]          wrb_data_q, wrb_data_d;
    logic                 wra_vld_q, wra_vld_d;
    logic [7:0]           wra_addr_q, wra_addr_d;
    logic [15:0]          wra_data_q, wra_data_d;
    logic                 err_trunc_q, err_trunc_d;
    logic                 err_dbl_q, err_dbl_d;
    logic [8:0]           free_cnt_q, free_cnt_d;

    logic                 any_free;
    logic [7:0]           free_idx;
    logic                 rel_ok;
    logic                 room;
    logic                 beat;

    // Word count saturates at MAX_WORDS; the descriptor size includes the current word if it fits.
    function automatic logic [7:0] sat_size(input logic [4:0] w);
        if (w >= MAXW) begin
            return {3'b000, MAXW};
        end
        return {3'b000, w + 5'd1};
    endfunction

    function automatic logic [8:0] count_free(input logic [N_SLOTS-1:0] b);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!b[i]) begin
                c = c + 9'd1;
            end
        end
        return c;
    endfunction

    assign any_free = ~&busy_q;
    assign room     = (wcnt_q < MAXW);
    assign beat     = bus.in_tvalid && (state_q == S_RECV);

    always_comb begin
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = 8'(i);
            end
        end
    end

    // Only a busy, in-range slot may be released; anything else is flagged.
    always_comb begin
        rel_ok = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (bus.rel_slot == 8'(i) && busy_q[i]) begin
                rel_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        slot_d      = slot_q;
        wcnt_d      = wcnt_q;
        wrb_vld_d   = 1'b0;
        wrb_addr_d  = wrb_addr_q;
        wrb_data_d  = wrb_data_q;
        wra_vld_d   = 1'b0;
        wra_addr_d  = wra_addr_q;
        wra_data_d  = wra_data_q;
        err_trunc_d = 1'b0;
        err_dbl_d   = 1'b0;

        if (bus.rel_valid) begin
            if (rel_ok) begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (bus.rel_slot == 8'(i)) begin
                        busy_d[i] = 1'b0;
                    end
                end
            end else begin
                err_dbl_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (any_free) begin
                    state_d = S_ALLOC;
                end
            end
            S_ALLOC: begin
                slot_d = free_idx;
                for (int i = 0; i < N_SLOTS; i++) begin
                    if (free_idx == 8'(i)) begin
                        busy_d[i] = 1'b1;
                    end
                end
                wcnt_d  = '0;
                state_d = S_RECV;
            end
            S_RECV: begin
                if (beat) begin
                    if (room) begin
                        wrb_vld_d  = 1'b1;
                        wrb_addr_d = {slot_q, wcnt_q[3:0]};
                        wrb_data_d = bus.in_tdata;
                        wcnt_d     = wcnt_q + 5'd1;
                    end
                    if (bus.in_tlast) begin
                        // Any dropped word leaves the count pinned at MAX_WORDS.
                        wra_vld_d   = 1'b1;
                        wra_addr_d  = slot_q;
                        wra_data_d  = {sat_size(wcnt_q), slot_q};
                        err_trunc_d = !room;
                        state_d     = S_DESC;
                    end
                end
            end
            S_DESC: begin
                state_d = S_PUSH;
            end
            S_PUSH: begin
                if (bus.out_tready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        free_cnt_d = count_free(busy_d);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            busy_q      <= '0;
            slot_q      <= '0;
            wcnt_q      <= '0;
            wrb_vld_q   <= 1'b0;
            wrb_addr_q  <= '0;
            wrb_data_q  <= '0;
            wra_vld_q   <= 1'b0;
            wra_addr_q  <= '0;
            wra_data_q  <= '0;
            err_trunc_q <= 1'b0;
            err_dbl_q   <= 1'b0;
            free_cnt_q  <= 9'(N_SLOTS);
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            slot_q      <= slot_d;
            wcnt_q      <= wcnt_d;
            wrb_vld_q   <= wrb_vld_d;
            wrb_addr_q  <= wrb_addr_d;
            wrb_data_q  <= wrb_data_d;
            wra_vld_q   <= wra_vld_d;
            wra_addr_q  <= wra_addr_d;
            wra_data_q  <= wra_data_d;
            err_trunc_q <= err_trunc_d;
            err_dbl_q   <= err_dbl_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign bus.in_tready    = (state_q == S_RECV);
    assign bus.out_tvalid   = (state_q == S_PUSH);
    assign bus.out_tdata    = slot_q;
    assign bus.wr_b_valid   = wrb_vld_q;
    assign bus.wr_b_addr    = wrb_addr_q;
    assign bus.wr_b_data    = wrb_data_q;
    assign bus.wr_a_valid   = wra_vld_q;
    assign bus.wr_a_addr    = wra_addr_q;
    assign bus.wr_a_data    = wra_data_q;
    assign bus.free_cnt     = free_cnt_q;
    assign bus.err_trunc    = err_trunc_q;
    assign bus.err_dbl_free = err_dbl_q;

endmodule
